// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe elastic register pipeline.
package dff_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid flag plus a data register that only changes on load.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  // A load wins over a clear so a stage that hands off and refills stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VAL;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/dff_pipe.sv
// Elastic valid/ready register pipeline with bubble collapse, flush and occupancy count.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [WIDTH-1:0]               out_data_n,
  output logic [occ_width(DEPTH)-1:0]    occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] stage_in [DEPTH];
  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  // Ready chain runs from the output back toward stage 0 so bubbles collapse.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = valid[DEPTH-1] & out_ready & ~reset;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = valid[i] & (~valid[i+1] | adv[i+1]);
    end
  end

  assign in_ready = (~valid[0] | adv[0]) & ~flush & ~reset;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = adv[DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign load[gi]     = in_fire & ~flush;
        assign stage_in[gi] = in_data;
      end else begin : g_body
        assign load[gi]     = adv[gi-1] & ~flush;
        assign stage_in[gi] = data[gi-1];
      end

      assign clear[gi] = flush | adv[gi];

      dff_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (load[gi]),
        .clear     (clear[gi]),
        .load_data (stage_in[gi]),
        .valid     (valid[gi]),
        .data      (data[gi])
      );
    end
  endgenerate

  // Tracking pushes and pops gives the same count as summing the valid bits.
  always_comb begin
    occ_next = occ_reg;
    if (flush) begin
      occ_next = '0;
    end else begin
      occ_next = occ_reg + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign out_valid  = valid[DEPTH-1] & ~reset;
  assign out_data   = reset ? RESET_VAL : data[DEPTH-1];
  assign out_data_n = ~out_data;
  assign occupancy  = occ_reg;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed testbench for dff_pipe: a DEPTH=4/WIDTH=8 instance plus a DEPTH=1/WIDTH=1 corner instance.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_data_n;
  logic [2:0] occupancy;

  logic       c_flush;
  logic       c_in_valid;
  logic       c_in_ready;
  logic [0:0] c_in_data;
  logic       c_out_valid;
  logic       c_out_ready;
  logic [0:0] c_out_data;
  logic [0:0] c_out_data_n;
  logic [0:0] c_occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_data_n (out_data_n),
    .occupancy  (occupancy)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut_c (
    .clk        (clk),
    .reset      (reset),
    .flush      (c_flush),
    .in_valid   (c_in_valid),
    .in_ready   (c_in_ready),
    .in_data    (c_in_data),
    .out_valid  (c_out_valid),
    .out_ready  (c_out_ready),
    .out_data   (c_out_data),
    .out_data_n (c_out_data_n),
    .occupancy  (c_occupancy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 1'b0; c_out_ready = 1'b0;
    tick;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL reset_out_data: got %h want a5", out_data); end
    n_cmp++; if (out_data_n !== 8'h5A) begin n_err++; $display("FAIL reset_out_data_n: got %h want 5a", out_data_n); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick;
    $display("test_reset: out_data=%h out_data_n=%h occupancy=%0d", out_data, out_data_n, occupancy);
  endtask

  task automatic test_latency;
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0; in_data = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (out_valid !== (c == 4)) begin n_err++; $display("FAIL lat_out_valid_c%0d: got %b want %b", c, out_valid, (c == 4)); end
      if (c < 4) tick;
    end
    n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL lat_out_data: got %h want 11", out_data); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_drained: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL lat_occupancy: got %0d want 0", occupancy); end
    $display("test_latency: pushed 11, seen at cycle 4");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept_%0d: got %b want 1", k, in_ready); end
      tick;
    end
    in_data = 8'h05;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_full_occupancy: got %0d want 4", occupancy); end
    tick;
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_hold_occupancy: got %0d want 4", occupancy); end
    n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL bp_hold_out_data: got %h want 01", out_data); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop_push_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin n_err++; $display("FAIL bp_order_%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'(k)); end
      tick;
    end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bp_empty: got %0d want 0", occupancy); end
    $display("test_backpressure: 01..05 delivered in order");
  endtask

  task automatic test_simultaneous;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(k);
      tick;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'h24 + 8'(i); out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sim_in_ready_%0d: got %b want 1", i, in_ready); end
      n_cmp++; if (out_data !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL sim_out_data_%0d: got %h want %h", i, out_data, 8'h20 + 8'(i)); end
      n_cmp++; if (out_data_n !== ~(8'h20 + 8'(i))) begin n_err++; $display("FAIL sim_out_data_n_%0d: got %h want %h", i, out_data_n, ~(8'h20 + 8'(i))); end
      tick;
      n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL sim_occupancy_%0d: got %0d want 4", i, occupancy); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data !== 8'h2A + 8'(i)) begin n_err++; $display("FAIL sim_drain_%0d: got %h want %h", i, out_data, 8'h2A + 8'(i)); end
      tick;
    end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL sim_empty: got %0d want 0", occupancy); end
    $display("test_simultaneous: 10 pop+push cycles at full occupancy");
  endtask

  task automatic test_flush;
    int seen;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(k);
      tick;
    end
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL fl_pre_occupancy: got %0d want 3", occupancy); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h34;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL fl_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h2D) begin n_err++; $display("FAIL fl_data_hold: got %h want 2d", out_data); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h35;
    tick;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        seen++;
        n_cmp++; if (out_data !== 8'h35) begin n_err++; $display("FAIL fl_after_data: got %h want 35", out_data); end
      end
      tick;
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL fl_after_count: got %0d want 1", seen); end
    $display("test_flush: only post-flush 35 emerged");
  endtask

  task automatic test_corner;
    logic [6:0] bits;
    bits = 7'b1001101;
    for (int c = 0; c < 14; c++) begin
      c_in_valid = 1'b1; c_in_data = bits[c/2]; c_out_ready = (c % 2 == 0);
      #1;
      n_cmp++; if (c_in_ready !== (c % 2 == 0)) begin n_err++; $display("FAIL c_in_ready_%0d: got %b want %b", c, c_in_ready, (c % 2 == 0)); end
      if (c > 0) begin
        n_cmp++; if (c_out_valid !== 1'b1 || c_out_data !== bits[(c-1)/2]) begin n_err++; $display("FAIL c_out_%0d: got v=%b d=%b want v=1 d=%b", c, c_out_valid, c_out_data, bits[(c-1)/2]); end
        n_cmp++; if (c_occupancy !== 1'b1) begin n_err++; $display("FAIL c_occupancy_%0d: got %0d want 1", c, c_occupancy); end
      end
      tick;
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (c_in_ready !== 1'b0) begin n_err++; $display("FAIL c_reset_in_ready: got %b want 0", c_in_ready); end
    tick;
    n_cmp++; if (c_occupancy !== 1'b0) begin n_err++; $display("FAIL c_reset_occupancy: got %0d want 0", c_occupancy); end
    n_cmp++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL c_reset_out_valid: got %b want 0", c_out_valid); end
    reset = 1'b0; c_in_valid = 1'b0;
    tick;
    n_cmp++; if (c_out_valid !== 1'b0 || c_occupancy !== 1'b0) begin n_err++; $display("FAIL c_post_reset: got v=%b occ=%0d want 0/0", c_out_valid, c_occupancy); end
    $display("test_corner: 7 bits through DEPTH=1 pipe, mid-stream reset cleared");
  endtask

  initial begin
    test_reset;
    test_latency;
    test_backpressure;
    test_simultaneous;
    test_flush;
    test_corner;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per stage, legal values 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of register stages, legal values 1 or more.
REQ-003 The block SHALL have parameter RESET_VAL, default 0 (WIDTH bits): value loaded into every data register at reset.
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: flush  input  1  discards all pipeline contents.
REQ-007 Port: in_valid  input  1  in_data is valid this cycle.
REQ-008 Port: in_ready  output  1  pipeline accepts in_data this cycle.
REQ-009 Port: in_data  input  WIDTH  write data.
REQ-010 Port: out_valid  output  1  out_data is valid.
REQ-011 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 Port: out_data  output  WIDTH  last-stage data.
REQ-013 Port: out_data_n  output  WIDTH  bitwise complement of out_data, driven combinationally.
REQ-014 Port: occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-015 The block SHALL hold DEPTH stages 0..DEPTH-1, each with a valid bit and a WIDTH-bit data register; stage DEPTH-1 drives out_valid and out_data.
REQ-016 The last stage SHALL advance when out_valid and out_ready are both high.
REQ-017 Stage i (i < DEPTH-1) SHALL advance when valid[i] is high and (valid[i+1] is low or stage i+1 advances), so bubbles collapse.
REQ-018 in_ready SHALL equal (valid[0] low or stage 0 advances) and flush low; it SHALL be combinational through the ready chain.
REQ-019 A transfer into stage 0 SHALL occur when in_valid and in_ready are both high; the data is loaded and valid[0] is set.
REQ-020 When a stage advances and nothing loads into it, its valid bit SHALL clear.
REQ-021 Data registers SHALL load only on a transfer; when not loading, the previous value SHALL hold, including while the valid bit is low.
REQ-022 Latency with no stalls SHALL be exactly DEPTH cycles from an accepted input to out_valid high with the same data.
REQ-023 Throughput SHALL be one transfer per cycle while out_ready is held high.
REQ-024 With out_ready low and all stages valid, in_ready SHALL be low and all state SHALL hold.
REQ-025 With the pipe full, if out_ready is high, in_ready SHALL be high in the same cycle, giving a simultaneous pop and push with no bubble.
REQ-026 flush SHALL clear every valid bit at the next edge; data registers hold.
REQ-027 During a flush cycle, no input SHALL be accepted and the output-side transfer SHALL still be visible if out_valid && out_ready.
REQ-028 occupancy SHALL be registered and SHALL equal the count of valid bits after each edge, with a range of 0..DEPTH.
REQ-029 Data order SHALL be strictly FIFO, and no accepted data SHALL be dropped or duplicated except by flush or reset.

Reset
REQ-030 On reset high at a clock edge, all valid bits SHALL go to 0, all data registers to RESET_VAL, and occupancy to 0.
REQ-031 While reset is high, in_ready and out_valid SHALL be 0; out_data SHALL be RESET_VAL and out_data_n SHALL be ~RESET_VAL.
REQ-032 reset SHALL have priority over flush and over any transfer; asserting reset mid-stream SHALL lose all in-flight data.

Structure
REQ-033 Default parameter constants and the occupancy-width function SHALL live in the shared package dff_pipe_pkg.
REQ-034 One stage SHALL be the sub-module dff_pipe_stage (valid register plus data register with load, clear and reset inputs), instantiated DEPTH times by a generate loop.
REQ-035 The block SHALL contain no latches and no asynchronous logic.

Verification
REQ-036 Reset: with WIDTH=8, RESET_VAL=8'hA5 and reset high for 2 cycles -> out_valid=0, out_data=8'hA5, out_data_n=8'h5A, occupancy=0.
REQ-037 Latency: with DEPTH=4 and out_ready=1, push 8'h11 at cycle 0 -> out_valid=1 with out_data=8'h11 at cycle 4, and no earlier.
REQ-038 Backpressure: with out_ready=0, push 8'h01..8'h05 -> 4 accepted, in_ready=0 and occupancy=4; then raise out_ready -> 8'h01..8'h04 emerge in order and 8'h05 is accepted on the first pop cycle.
REQ-039 Simultaneous: with the pipe full and out_ready=1, in_valid=1 for 10 cycles -> in_ready stays 1, occupancy stays 4, and sequence order is preserved.
REQ-040 Flush: with occupancy=3, assert flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, occupancy=0 next cycle, and no flushed data later appears.
REQ-041 Corner: with DEPTH=1 and WIDTH=1, alternate out_ready 1/0 with continuous input -> every accepted bit appears exactly once in order; reset mid-stream clears occupancy to 0.
